// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
//   Shared definitions for the program counter slice.
//   - PC_WIDTH_DEFAULT : default PC/address width in bits
//   - PC_RESET_DEFAULT : default value the PC takes while reset is asserted
//   - pc_sel_e         : decoded next-PC select (hold / increment / load)
//   - pc_decode()      : priority decode of the LoadPC/IncPC control pair
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT = 8;
    localparam int unsigned PC_RESET_DEFAULT = 0;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD
    } pc_sel_e;

    // Load has priority over increment; neither asserted means hold.
    function automatic pc_sel_e pc_decode(input logic load_pc, input logic inc_pc);
        if (load_pc) begin
            return PC_LOAD;
        end
        if (inc_pc) begin
            return PC_INC;
        end
        return PC_HOLD;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
//   Combinational next-PC selection for program_counter.
//   Optional feature macro: PC_WRAP_DETECT_EN (adds wrap_cond output).
//   Ports:
//     LoadPC     in   1      load request (highest priority)
//     IncPC      in   1      increment request
//     count      in   WIDTH  current PC value
//     new_count  in   WIDTH  load target address
//     next_count out  WIDTH  PC value to register on the next edge
//     wrap_cond  out  1      increment from all-ones to zero this cycle
//                            (only with PC_WRAP_DETECT_EN)
// ---------------------------------------------------------------------------
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH_DEFAULT
) (
    input  logic             LoadPC,
    input  logic             IncPC,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] new_count,
    output logic [WIDTH-1:0] next_count
`ifdef PC_WRAP_DETECT_EN
    ,
    output logic             wrap_cond
`endif
);

    pc_sel_e sel;

    always_comb begin
        sel = pc_decode(LoadPC, IncPC);
    end

    always_comb begin
        next_count = count;
        case (sel)
            PC_LOAD: next_count = new_count;
            // Natural overflow of the WIDTH-bit add gives modulo-2^WIDTH wrap.
            PC_INC:  next_count = count + WIDTH'(1);
            PC_HOLD: next_count = count;
            default: next_count = count;
        endcase
    end

`ifdef PC_WRAP_DETECT_EN
    // Only a genuine increment out of all-ones counts; a load of zero does not.
    always_comb begin
        wrap_cond = (sel == PC_INC) && (count == '1);
    end
`endif

endmodule

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//   Processor program counter: holds, increments by one, or loads a jump
//   target on each rising clock edge. Reset is asynchronous, active-low.
//   Optional feature macro: PC_WRAP_DETECT_EN (adds the wrap output).
//   Ports:
//     clk        in   1      rising-edge system clock
//     reset      in   1      asynchronous active-low reset (0 = reset)
//     LoadPC     in   1      load new_count on next edge (wins over IncPC)
//     IncPC      in   1      increment count on next edge
//     new_count  in   WIDTH  jump/branch target address
//     count      out  WIDTH  current PC, registered
//     wrap       out  1      one-cycle pulse when an increment wraps to 0
//                            (only with PC_WRAP_DETECT_EN)
// ---------------------------------------------------------------------------
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH       = PC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             LoadPC,
    input  logic             IncPC,
    input  logic [WIDTH-1:0] new_count,
    output logic [WIDTH-1:0] count
`ifdef PC_WRAP_DETECT_EN
    ,
    output logic             wrap
`endif
);

    logic [WIDTH-1:0] next_count;
`ifdef PC_WRAP_DETECT_EN
    logic             wrap_cond;
`endif

    pc_next_sel #(
        .WIDTH(WIDTH)
    ) u_next_sel (
        .LoadPC    (LoadPC),
        .IncPC     (IncPC),
        .count     (count),
        .new_count (new_count),
        .next_count(next_count)
`ifdef PC_WRAP_DETECT_EN
        ,
        .wrap_cond (wrap_cond)
`endif
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RESET_VALUE;
        end else begin
            count <= next_count;
        end
    end

`ifdef PC_WRAP_DETECT_EN
    // Registered pulse: cleared on any edge without a fresh wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_cond;
        end
    end
`endif

endmodule

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
//   Self-checking bench for program_counter (WIDTH=8, RESET_VALUE=0).
//   Directed steps followed by randomized commands, checked against a
//   behavioural model built from plain modulo arithmetic.
//   Honours PC_WRAP_DETECT_EN to connect and check the wrap output.
// ---------------------------------------------------------------------------
module tb_program_counter;

    localparam int unsigned W    = 8;
    localparam int unsigned MODV = 256;

    logic         clk = 1'b0;
    logic         reset;
    logic         LoadPC;
    logic         IncPC;
    logic [W-1:0] new_count;
    logic [W-1:0] count;
`ifdef PC_WRAP_DETECT_EN
    logic         wrap;
`endif

    program_counter #(
        .WIDTH      (W),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .LoadPC   (LoadPC),
        .IncPC    (IncPC),
        .new_count(new_count),
        .count    (count)
`ifdef PC_WRAP_DETECT_EN
        ,
        .wrap     (wrap)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    int unsigned m_pc   = 0;
    int unsigned m_wrap = 0;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_count"}, int'(count), m_pc);
`ifdef PC_WRAP_DETECT_EN
        check({tag, "_wrap"}, int'(wrap), m_wrap);
`endif
    endtask

    // One rising edge: sample the commands, advance the model, check #1 later.
    task automatic tick(input string tag);
        logic        rs;
        logic        ld;
        logic        ic;
        int unsigned nc;
        rs = reset;
        ld = LoadPC;
        ic = IncPC;
        nc = int'(new_count);
        @(posedge clk);
        if (!rs) begin
            m_pc   = 0;
            m_wrap = 0;
        end else if (ld) begin
            m_pc   = nc;
            m_wrap = 0;
        end else if (ic) begin
            m_wrap = (m_pc == MODV - 1) ? 1 : 0;
            m_pc   = (m_pc + 1) % MODV;
        end else begin
            m_wrap = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        // Reset held with a load pending: must be ignored.
        reset     = 1'b0;
        LoadPC    = 1'b1;
        IncPC     = 1'b0;
        new_count = 8'h11;
        #1;
        check_outputs("rst_init");
        tick("rst_e1");
        tick("rst_e2");

        // Release mid-cycle, then load.
        #2 reset = 1'b1;
        tick("load");

        // Increment twice; new_count is don't-care.
        LoadPC = 1'b0;
        IncPC  = 1'b1;
        new_count = 8'($urandom);
        tick("inc1");
        new_count = 8'($urandom);
        tick("inc2");

        // Load has priority over increment.
        LoadPC    = 1'b1;
        new_count = 8'h11;
        tick("prio");

        // Hold.
        LoadPC = 1'b0;
        IncPC  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            new_count = 8'($urandom);
            tick("hold");
        end

        // Wrap from all-ones by increment; pulse lasts one cycle.
        LoadPC    = 1'b1;
        new_count = 8'hFF;
        tick("load_ff");
        LoadPC = 1'b0;
        IncPC  = 1'b1;
        tick("wrap");
        IncPC = 1'b0;
        tick("wrap_clr");

        // Load of zero from all-ones is not a wrap.
        LoadPC    = 1'b1;
        new_count = 8'hFF;
        tick("load_ff2");
        new_count = 8'h00;
        tick("load_zero");

        // Mid-operation reset: async drop without a clock edge.
        LoadPC = 1'b0;
        IncPC  = 1'b1;
        tick("stream1");
        tick("stream2");
        #2 reset = 1'b0;
        #1;
        m_pc   = 0;
        m_wrap = 0;
        check_outputs("midrst_async");
        tick("midrst_edge");
        #2 reset = 1'b1;
        tick("midrst_rel");

        // Randomized commands with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            LoadPC    = 1'($urandom_range(0, 3) == 0);
            IncPC     = 1'($urandom_range(0, 1));
            // Bias loads toward the top of the range to exercise wrap often.
            new_count = ($urandom_range(0, 1) == 1) ? 8'hFE + 8'($urandom_range(0, 1))
                                                     : 8'($urandom);
            reset     = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            tick("rand");
            if (!reset) begin
                #2 reset = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety bound in case the clock or sequence stalls.
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
